// File: rtl/inst_encoder_loader_if.sv
// inst_encoder_loader_if
//   Bundles the loader's two buses: the instruction-field handshake
//   (in_valid/in_ready plus the fields) and the instruction-memory
//   write port (imem_we/imem_addr/imem_wdata).
//   master: the producer of fields and the consumer of memory writes
//           (program source / testbench / memory side).
//   slave : the loader itself.
// Parameters
//   ADDR_W  word-address width of instruction memory
interface inst_encoder_loader_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [4:0]        in_imm;
    logic              in_dir;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_dir,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_dir,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/inst_encoder_loader.sv
// inst_encoder_loader
//   Assembles ld/sd/and/or/add/sub/beq/blt words from discrete fields and
//   writes them to instruction memory at consecutive word addresses,
//   starting at 0 on each start pulse. Field placement mirrors the decoder.
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start, finish   pulses that begin / end a program load
//   bus (slave)     field handshake in, memory write port out
//   busy            loader is not idle
//   done            one-cycle pulse at the end of a load
//   count           words written in the current load (incl. halt word)
//   overflow        sticky: an op was presented while memory was full
// Configuration
//   INST_LOADER_HALT_PAD_EN  when defined, finish appends a self-loop
//                            beq x0,x0,0 word unless memory is full.
module inst_encoder_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 finish,
    inst_encoder_loader_if.slave bus,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W:0]      count,
    output logic                 overflow
);
    localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [31:0]     HALT_WORD = 32'h0000_0063;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
`ifdef INST_LOADER_HALT_PAD_EN
        S_HALT,
`endif
        S_DONE
    } state_t;

    state_t            state;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              full;
    logic              last_slot;
    logic              ready;
    logic              accept;

    function automatic logic [31:0] encode(
        input logic [2:0] op,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic [4:0] imm,
        input logic       dir
    );
        logic [31:0] w;
        case (op)
            3'd0:    w = {7'b0000000, imm, rs1, 3'b011, rd,  7'b0000011};
            3'd1:    w = {7'b0000000, rs2, rs1, 3'b011, imm, 7'b0100011};
            3'd2:    w = {7'b0000000, rs2, rs1, 3'b111, rd,  7'b0110011};
            3'd3:    w = {7'b0000000, rs2, rs1, 3'b110, rd,  7'b0110011};
            3'd4:    w = {7'b0000000, rs2, rs1, 3'b000, rd,  7'b0110011};
            3'd5:    w = {7'b0100000, rs2, rs1, 3'b000, rd,  7'b0110011};
            3'd6:    w = {6'b000000, dir, rs2, rs1, 3'b000, imm, 7'b1100011};
            default: w = {6'b000000, dir, rs2, rs1, 3'b100, imm, 7'b1100011};
        endcase
        return w;
    endfunction

    assign full      = (count == DEPTH);
    assign last_slot = (count == DEPTH - 1'b1);
    // start takes priority over a same-cycle op; reset masks the handshake.
    assign ready     = (state == S_LOAD) && !full && !start && !reset;
    assign accept    = bus.in_valid && ready;

    assign bus.in_ready   = ready;
    // Gating with reset drops a write registered just before reset arrives.
    assign bus.imem_we    = we_q && !reset;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign busy           = (state != S_IDLE);
    assign done           = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (accept) begin
                we_q    <= 1'b1;
                addr_q  <= count[ADDR_W-1:0];
                wdata_q <= encode(bus.in_op, bus.in_rd, bus.in_rs1,
                                  bus.in_rs2, bus.in_imm, bus.in_dir);
                count   <= count + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        count    <= '0;
                        overflow <= 1'b0;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (start) begin
                        count    <= '0;
                        overflow <= 1'b0;
                    end else begin
                        if (bus.in_valid && full)
                            overflow <= 1'b1;
                        if (finish) begin
`ifdef INST_LOADER_HALT_PAD_EN
                            // Fullness must account for an op accepted this same edge.
                            state <= (full || (accept && last_slot)) ? S_DONE : S_HALT;
`else
                            state <= S_DONE;
`endif
                        end
                    end
                end
`ifdef INST_LOADER_HALT_PAD_EN
                S_HALT: begin
                    if (!full) begin
                        we_q    <= 1'b1;
                        addr_q  <= count[ADDR_W-1:0];
                        wdata_q <= HALT_WORD;
                        count   <= count + 1'b1;
                    end
                    state <= S_DONE;
                end
`endif
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifndef INST_LOADER_HALT_PAD_EN
    logic unused_last_slot;
    assign unused_last_slot = last_slot;
`endif
endmodule

// File: tb/tb_inst_encoder_loader.sv
module tb_inst_encoder_loader;
    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 1 << AW;
`ifdef INST_LOADER_HALT_PAD_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    typedef struct {
        int unsigned op, rd, rs1, rs2, imm, dir;
    } op_t;

    logic          clk = 1'b0;
    logic          reset, start, finish;
    logic          busy, done, overflow;
    logic [AW:0]   count;
    logic          mem_clr;
    logic [31:0]   mem_got [DEPTH];
    int unsigned   wr_cnt;
    int            checks = 0;
    int            errors = 0;

    // reference model state
    int unsigned   m_count;
    bit            m_ovf;
    logic [31:0]   m_mem [DEPTH];
    int unsigned   m_writes;

    inst_encoder_loader_if #(.ADDR_W(AW)) bus ();

    inst_encoder_loader #(.ADDR_W(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .finish   (finish),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // instruction memory image as seen through the write port
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < DEPTH; i++) mem_got[i] <= '0;
            wr_cnt <= 0;
        end else if (bus.imem_we) begin
            mem_got[bus.imem_addr] <= bus.imem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_encode(input op_t o);
        int unsigned opc, f3, f7, dst, src2;
        opc = 'h33; f3 = 0; f7 = 0; dst = o.rd; src2 = o.rs2;
        case (o.op)
            0: begin opc = 'h03; f3 = 3; src2 = o.imm; end
            1: begin opc = 'h23; f3 = 3; dst = o.imm; end
            2: f3 = 7;
            3: f3 = 6;
            4: f3 = 0;
            5: f7 = 32;
            6: begin opc = 'h63; f3 = 0; dst = o.imm; f7 = o.dir; end
            default: begin opc = 'h63; f3 = 4; dst = o.imm; f7 = o.dir; end
        endcase
        return opc + (dst << 7) + (f3 << 12) + (o.rs1 << 15) + (src2 << 20) + (f7 << 25);
    endfunction

    function automatic op_t mk(input int unsigned op, rd, rs1, rs2, imm, dir);
        op_t o;
        o.op = op; o.rd = rd; o.rs1 = rs1; o.rs2 = rs2; o.imm = imm; o.dir = dir;
        return o;
    endfunction

    function automatic op_t rand_op();
        return mk($urandom_range(7, 0), $urandom_range(31, 0), $urandom_range(31, 0),
                  $urandom_range(31, 0), $urandom_range(31, 0), $urandom_range(1, 0));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rd = '0; bus.in_rs1 = '0;
        bus.in_rs2 = '0; bus.in_imm = '0; bus.in_dir = 1'b0;
    endtask

    task automatic drive_op(input op_t o);
        bus.in_valid = 1'b1;
        bus.in_op  = 3'(o.op);  bus.in_rd  = 5'(o.rd);  bus.in_rs1 = 5'(o.rs1);
        bus.in_rs2 = 5'(o.rs2); bus.in_imm = 5'(o.imm); bus.in_dir = 1'(o.dir);
    endtask

    task automatic model_clear();
        m_count = 0; m_ovf = 1'b0; m_writes = 0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    endtask

    task automatic model_offer(input op_t o);
        if (m_count < DEPTH) begin
            m_mem[m_count] = ref_encode(o);
            m_count++;
            m_writes++;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic model_finish();
        if (HALT_EN && m_count < DEPTH) begin
            m_mem[m_count] = 32'h0000_0063;
            m_count++;
            m_writes++;
        end
    endtask

    initial begin
        op_t         o;
        op_t         ov_ops [6];
        int unsigned nops;
        bit          fin;
        bit          seen;

        reset = 1'b1; start = 1'b0; finish = 1'b0; mem_clr = 1'b1;
        drive_idle();
        clk_step(); clk_step();
        mem_clr = 1'b0;
        // reset state
        chk("rst_we",       bus.imem_we,    0);
        chk("rst_addr",     bus.imem_addr,  0);
        chk("rst_wdata",    bus.imem_wdata, 0);
        chk("rst_done",     done,           0);
        chk("rst_count",    count,          0);
        chk("rst_overflow", overflow,       0);
        chk("rst_busy",     busy,           0);
        chk("rst_ready",    bus.in_ready,   0);
        reset = 1'b0;
        clk_step();

        // add x3,x1,x2
        start = 1'b1; clk_step(); start = 1'b0;
        chk("add_busy", busy, 1);
        drive_op(mk(4, 3, 1, 2, 0, 0));
        #1 chk("add_ready", bus.in_ready, 1);
        clk_step(); drive_idle();
        chk("add_we",    bus.imem_we,    1);
        chk("add_addr",  bus.imem_addr,  0);
        chk("add_wdata", bus.imem_wdata, 32'h002081B3);
        chk("add_count", count,          1);

        // sub x5,x6,x7 then ld x4,x1,8, back to back after a restart
        start = 1'b1; clk_step(); start = 1'b0;
        chk("restart_count", count, 0);
        drive_op(mk(5, 5, 6, 7, 0, 0));
        clk_step();
        chk("sub_we",    bus.imem_we,    1);
        chk("sub_addr",  bus.imem_addr,  0);
        chk("sub_wdata", bus.imem_wdata, 32'h407302B3);
        drive_op(mk(0, 4, 1, 0, 8, 0));
        clk_step(); drive_idle();
        chk("ld_we",    bus.imem_we,    1);
        chk("ld_addr",  bus.imem_addr,  1);
        chk("ld_wdata", bus.imem_wdata, 32'h0080B203);
        chk("ld_count", count,          2);
        clk_step();
        chk("idle_we", bus.imem_we, 0);

        // blt then finish, load terminated with or without halt pad
        start = 1'b1; mem_clr = 1'b1; clk_step(); start = 1'b0; mem_clr = 1'b0;
        drive_op(mk(7, 0, 1, 2, 3, 1));
        clk_step(); drive_idle();
        finish = 1'b1;
        chk("blt_we",    bus.imem_we,    1);
        chk("blt_addr",  bus.imem_addr,  0);
        chk("blt_wdata", bus.imem_wdata, 32'h0220C1E3);
        clk_step(); finish = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("blt_done",  done,        (c == int'(HALT_EN)));
            chk("blt_tailwe", bus.imem_we, (HALT_EN && c == 1));
            clk_step();
        end
        chk("blt_halt_word", mem_got[1], HALT_EN ? 32'h0000_0063 : 32'h0);
        chk("blt_count",     count,      1 + int'(HALT_EN));
        chk("blt_idle",      busy,       0);

        // fill memory and keep presenting ops
        start = 1'b1; mem_clr = 1'b1; clk_step(); start = 1'b0; mem_clr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ov_ops[i] = rand_op();
            drive_op(ov_ops[i]);
            #1 chk("ovf_ready", bus.in_ready, (i < 4));
            clk_step();
        end
        drive_idle();
        chk("ovf_flag",  overflow, 1);
        chk("ovf_count", count,    4);
        for (int i = 0; i < 4; i++) chk("ovf_mem", mem_got[i], ref_encode(ov_ops[i]));

        // restart clears overflow, then restart again at count 3
        start = 1'b1; clk_step(); start = 1'b0;
        chk("rs_count", count,    0);
        chk("rs_ovf",   overflow, 0);
        for (int i = 0; i < 3; i++) begin drive_op(rand_op()); clk_step(); end
        drive_idle();
        chk("rs3_count", count, 3);
        start = 1'b1; clk_step(); start = 1'b0;
        chk("rs3_zero", count, 0);
        o = rand_op();
        drive_op(o); clk_step(); drive_idle();
        chk("rs3_we",    bus.imem_we,    1);
        chk("rs3_addr",  bus.imem_addr,  0);
        chk("rs3_wdata", bus.imem_wdata, ref_encode(o));
        finish = 1'b1; clk_step(); finish = 1'b0;
        clk_step(); clk_step(); clk_step();

        // reset the cycle after an accept
        start = 1'b1; clk_step(); start = 1'b0;
        drive_op(rand_op()); clk_step(); drive_idle();
        reset = 1'b1;
        #1 chk("mrst_we_now", bus.imem_we, 0);
        clk_step();
        chk("mrst_we",    bus.imem_we, 0);
        chk("mrst_busy",  busy,        0);
        chk("mrst_count", count,       0);
        reset = 1'b0;
        // start with a simultaneous op
        start = 1'b1; drive_op(rand_op());
        #1 chk("st_ready", bus.in_ready, 0);
        clk_step(); start = 1'b0; drive_idle();
        chk("st_count", count, 0);
        chk("st_busy",  busy,  1);
        chk("st_we",    bus.imem_we, 0);
        finish = 1'b1; clk_step(); finish = 1'b0;
        clk_step(); clk_step(); clk_step();

        // randomized loads against the model
        for (int it = 0; it < 24; it++) begin
            nops = $urandom_range(DEPTH + 2, 0);
            fin  = 1'b0;
            model_clear();
            start = 1'b1; mem_clr = 1'b1; clk_step(); start = 1'b0; mem_clr = 1'b0;
            for (int k = 0; k < nops; k++) begin
                o = rand_op();
                if ($urandom_range(3, 0) == 0) begin drive_idle(); clk_step(); end
                drive_op(o);
                fin = (k == nops - 1) && ($urandom_range(1, 0) == 1);
                finish = fin;
                #1 chk("rnd_ready", bus.in_ready, (m_count < DEPTH));
                model_offer(o);
                clk_step();
                finish = 1'b0;
            end
            drive_idle();
            if (!fin) begin finish = 1'b1; clk_step(); finish = 1'b0; end
            model_finish();
            seen = 1'b0;
            for (int w = 0; w < 6; w++) begin
                if (done) begin seen = 1'b1; break; end
                clk_step();
            end
            chk("rnd_done_seen", seen,     1);
            chk("rnd_count",     count,    m_count);
            chk("rnd_overflow",  overflow, m_ovf);
            clk_step();
            chk("rnd_we_after", bus.imem_we, 0);
            chk("rnd_busy",     busy,        0);
            chk("rnd_writes",   wr_cnt,      m_writes);
            for (int i = 0; i < DEPTH; i++) chk("rnd_mem", mem_got[i], m_mem[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
